text_glyph_renderer: RTL and testbench
======================================

TEXT_GLYPH_RENDERER -- requirements
Module: text_glyph_renderer

Interface
REQ-001 Parameter GLYPH_W, default 8, glyph width in pixels (power of 2).
REQ-002 Parameter GLYPH_H, default 16, glyph height in pixels (power of 2).
REQ-003 Parameter COLS, default 20, character columns per screen.
REQ-004 Parameter ROWS, default 7, character rows per screen.
REQ-005 Parameter COLOUR_W, default 3, colour width in bits.
REQ-006 Parameters X_W (default 8) and Y_W (default 7) SHALL set the pixel coordinate widths.
REQ-007 Port clk, in, 1, the single clock; all state SHALL change on its rising edge only.
REQ-008 Port reset_n, in, 1, asynchronous active-low reset.
REQ-009 Ports char_valid in 1, char_ready out 1, char_code in 7: character handshake.
REQ-010 Ports fg_colour in COLOUR_W, bg_colour in COLOUR_W: ink and paper colours.
REQ-011 Ports glyph_char out 7, glyph_row out log2(GLYPH_H), glyph_bits in GLYPH_W: glyph ROM read, data valid one cycle after address.
REQ-012 Ports x out X_W, y out Y_W, colour out COLOUR_W, plot out 1: pixel write to the frame adapter.
REQ-013 Ports cursor_col out log2(COLS), cursor_row out log2(ROWS): current cell.

Function
REQ-014 A transfer SHALL occur on a rising edge where char_valid and char_ready are both 1; char_code, fg_colour and bg_colour SHALL be latched at that edge.
REQ-015 char_ready SHALL be 1 only in state IDLE; states are IDLE, FETCH, WAIT_ROM, DRAW, ADVANCE, CLEAR.
REQ-016 Printable code 0x20-0x7E: IDLE->FETCH; FETCH drives glyph_char/glyph_row for 1 cycle; WAIT_ROM latches glyph_bits after 1 cycle; DRAW emits GLYPH_W plots; repeat for all GLYPH_H rows; then ADVANCE (1 cycle) -> IDLE.
REQ-017 Glyph latency SHALL be exactly GLYPH_H*(GLYPH_W+2)+1 cycles from transfer edge to char_ready=1 (161 at defaults), with exactly GLYPH_W*GLYPH_H plot pulses.
REQ-018 Pixel (px,py) SHALL be written at x = cursor_col*GLYPH_W+px, y = cursor_row*GLYPH_H+py; glyph_bits MSB is px=0; colour = fg_colour if bit=1 else bg_colour.
REQ-019 x, y, colour, plot SHALL be registered and change together; plot SHALL be 1 for exactly one cycle per pixel.
REQ-020 ADVANCE after a glyph: cursor_col+1; at COLS-1 wrap to col 0 and row+1; at row ROWS-1 wrap to row 0 (no scroll).
REQ-021 0x0A or 0x0D: no plots; cursor_col=0, row+1 with same wrap; char_ready returns 1 after 2 cycles.
REQ-022 0x08 backspace: move cursor back one cell (col 0 -> col COLS-1 of row-1); then erase that cell using REQ-016 timing with glyph_bits forced to 0 (all bg_colour); cursor stays on erased cell; at (0,0) no plots, no move.
REQ-023 0x0C: enter CLEAR; plot bg_colour over COLS*GLYPH_W by ROWS*GLYPH_H pixels in raster order, one per cycle (17920 at defaults); then cursor (0,0), IDLE.
REQ-024 All other codes SHALL be accepted and discarded: no plots, no cursor change, char_ready returns 1 after 1 cycle.
REQ-025 char_valid changes while char_ready=0 SHALL have no effect.

Reset
REQ-026 reset_n=0 SHALL immediately, independent of clk, force state IDLE, plot 0, x 0, y 0, colour 0, cursor (0,0), glyph_char 0, glyph_row 0, char_ready 1.
REQ-027 Reset asserted mid-DRAW or mid-CLEAR SHALL abort the operation with no further plot pulses; the first transfer after release SHALL be accepted normally.

Verification
REQ-028 Reset release, send 'A' (0x41), ROM row = 8'h81 for all rows -> 128 plots at x 0..7, y 0..15; colour fg at px 0 and 7, bg elsewhere; char_ready high 161 cycles after transfer; cursor (1,0).
REQ-029 Send 20 printable chars then 7 newlines -> cursor wraps to (0,1) after 20th char, then to (0,1) again after 7 newlines (row wrap 6->0->1).
REQ-030 Cursor (0,1), send 0x08 -> cursor (19,0), 128 bg plots at x 152..159, y 0..15; at (0,0) 0x08 -> zero plots.
REQ-031 Send 0x0C with bg=3'b001 -> exactly 17920 plots covering x 0..159, y 0..111, all colour 3'b001, cursor (0,0).
REQ-032 Assert reset_n=0 at the 40th plot of a glyph -> plot falls same cycle, no more plots, char_ready=1, cursor (0,0); next 'B' draws at x 0..7.
REQ-033 Send 0x7F and hold char_valid during a glyph -> 0x7F gives no plots; held valid accepted only once char_ready=1.

Source files
------------

// File: rtl/text_glyph_renderer.sv
// Character-cell text renderer: takes character codes over a valid/ready handshake,
// reads glyph rows from an external synchronous ROM and emits one pixel write per cycle.
module text_glyph_renderer #(
  parameter int GLYPH_W  = 8,
  parameter int GLYPH_H  = 16,
  parameter int COLS     = 20,
  parameter int ROWS     = 7,
  parameter int COLOUR_W = 3,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  localparam int GR_W    = $clog2(GLYPH_H),
  localparam int PX_W    = $clog2(GLYPH_W),
  localparam int CC_W    = $clog2(COLS),
  localparam int CR_W    = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                char_valid,
  output logic                char_ready,
  input  logic [6:0]          char_code,
  input  logic [COLOUR_W-1:0] fg_colour,
  input  logic [COLOUR_W-1:0] bg_colour,
  output logic [6:0]          glyph_char,
  output logic [GR_W-1:0]     glyph_row,
  input  logic [GLYPH_W-1:0]  glyph_bits,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic [CC_W-1:0]     cursor_col,
  output logic [CR_W-1:0]     cursor_row
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, DRAW, ADVANCE, CLEAR} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_GLYPH, OP_NL, OP_ERASE} op_t;

  localparam logic [CC_W-1:0] COL_LAST   = CC_W'(COLS - 1);
  localparam logic [CR_W-1:0] ROW_LAST   = CR_W'(ROWS - 1);
  localparam logic [PX_W-1:0] PX_LAST    = PX_W'(GLYPH_W - 1);
  localparam logic [GR_W-1:0] PY_LAST    = GR_W'(GLYPH_H - 1);
  localparam logic [X_W-1:0]  CLR_X_LAST = X_W'(COLS * GLYPH_W - 1);
  localparam logic [Y_W-1:0]  CLR_Y_LAST = Y_W'(ROWS * GLYPH_H - 1);

  state_t                state_q;
  op_t                   op_q;
  logic [CC_W-1:0]       col_q;
  logic [CR_W-1:0]       row_q;
  logic [6:0]            glyph_char_q;
  logic [GR_W-1:0]       glyph_row_q;
  logic [COLOUR_W-1:0]   fg_q, bg_q;
  logic [PX_W-1:0]       px_q;
  logic [GR_W-1:0]       py_q;
  logic [GLYPH_W-1:0]    bits_q;
  logic [X_W-1:0]        clr_x_q;
  logic [Y_W-1:0]        clr_y_q;
  logic [X_W-1:0]        x_q;
  logic [Y_W-1:0]        y_q;
  logic [COLOUR_W-1:0]   colour_q;
  logic                  plot_q;

  logic [CC_W-1:0]       col_inc_d;
  logic [CR_W-1:0]       row_inc_d;
  logic [X_W-1:0]        draw_x_d;
  logic [Y_W-1:0]        draw_y_d;
  logic [GLYPH_W-1:0]    bits_shift_d;
  logic                  pix_on_d;
  logic                  printable_d;

  assign col_inc_d    = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
  assign row_inc_d    = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
  assign draw_x_d     = (X_W'(col_q) << PX_W) + X_W'(px_q);
  assign draw_y_d     = (Y_W'(row_q) << GR_W) + Y_W'(py_q);
  assign bits_shift_d = bits_q << px_q;
  assign pix_on_d     = bits_shift_d[GLYPH_W-1];
  assign printable_d  = (char_code >= 7'h20) && (char_code <= 7'h7E);

  // Whole controller in one block; every output below is a register so x/y/colour/plot move together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      op_q         <= OP_NOP;
      col_q        <= '0;
      row_q        <= '0;
      glyph_char_q <= '0;
      glyph_row_q  <= '0;
      fg_q         <= '0;
      bg_q         <= '0;
      px_q         <= '0;
      py_q         <= '0;
      bits_q       <= '0;
      clr_x_q      <= '0;
      clr_y_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (char_valid) begin
            glyph_char_q <= char_code;
            fg_q         <= fg_colour;
            bg_q         <= bg_colour;
            px_q         <= '0;
            py_q         <= '0;
            glyph_row_q  <= '0;
            if (printable_d) begin
              op_q    <= OP_GLYPH;
              state_q <= FETCH;
            end else if (char_code == 7'h0A || char_code == 7'h0D) begin
              op_q    <= OP_NL;
              state_q <= ADVANCE;
            end else if (char_code == 7'h08) begin
              if (col_q == '0 && row_q == '0) begin
                op_q    <= OP_NOP;
                state_q <= ADVANCE;
              end else begin
                // Step back first so the erase draws into the cell being removed.
                op_q    <= OP_ERASE;
                state_q <= FETCH;
                if (col_q == '0) begin
                  col_q <= COL_LAST;
                  row_q <= row_q - 1'b1;
                end else begin
                  col_q <= col_q - 1'b1;
                end
              end
            end else if (char_code == 7'h0C) begin
              clr_x_q <= '0;
              clr_y_q <= '0;
              state_q <= CLEAR;
            end else begin
              op_q    <= OP_NOP;
              state_q <= ADVANCE;
            end
          end
        end
        FETCH: state_q <= WAIT_ROM;
        WAIT_ROM: begin
          bits_q  <= (op_q == OP_ERASE) ? '0 : glyph_bits;
          px_q    <= '0;
          state_q <= DRAW;
        end
        DRAW: begin
          plot_q   <= 1'b1;
          x_q      <= draw_x_d;
          y_q      <= draw_y_d;
          colour_q <= pix_on_d ? fg_q : bg_q;
          px_q     <= px_q + 1'b1;
          if (px_q == PX_LAST) begin
            if (py_q == PY_LAST) begin
              state_q <= ADVANCE;
            end else begin
              py_q        <= py_q + 1'b1;
              glyph_row_q <= py_q + 1'b1;
              state_q     <= FETCH;
            end
          end
        end
        ADVANCE: begin
          // A newline spends two cycles here: the move, then a plain exit.
          unique case (op_q)
            OP_GLYPH: begin
              col_q   <= col_inc_d;
              if (col_q == COL_LAST) row_q <= row_inc_d;
              state_q <= IDLE;
            end
            OP_NL: begin
              col_q <= '0;
              row_q <= row_inc_d;
              op_q  <= OP_NOP;
            end
            default: state_q <= IDLE;
          endcase
        end
        CLEAR: begin
          plot_q   <= 1'b1;
          x_q      <= clr_x_q;
          y_q      <= clr_y_q;
          colour_q <= bg_q;
          if (clr_x_q == CLR_X_LAST) begin
            clr_x_q <= '0;
            if (clr_y_q == CLR_Y_LAST) begin
              col_q   <= '0;
              row_q   <= '0;
              state_q <= IDLE;
            end else begin
              clr_y_q <= clr_y_q + 1'b1;
            end
          end else begin
            clr_x_q <= clr_x_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign char_ready = (state_q == IDLE);
  assign glyph_char = glyph_char_q;
  assign glyph_row  = glyph_row_q;
  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_text_glyph_renderer.sv
// Directed bench for text_glyph_renderer: models the glyph ROM and checks every plotted
// pixel's position and colour against a behavioural raster-order model.
module tb_text_glyph_renderer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       char_valid;
  logic       char_ready;
  logic [6:0] char_code;
  logic [2:0] fg_colour, bg_colour;
  logic [6:0] glyph_char;
  logic [3:0] glyph_row;
  logic [7:0] glyph_bits;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [4:0] cursor_col;
  logic [2:0] cursor_row;

  int errors = 0, checks = 0;
  int cycleCnt = 0, xferCycle = 0, xferCount = 0;
  int plotCount = 0, totalPlots = 0, posBad = 0, colBad = 0;
  int minX, maxX, minY, maxY;
  logic [6:0] mChar;
  logic [2:0] mFg, mBg;
  bit   mBgOnly;
  int   mBaseX, mBaseY, mSpan = 8;
  int   lat;

  text_glyph_renderer dut (
    .clk(clk), .reset_n(reset_n),
    .char_valid(char_valid), .char_ready(char_ready), .char_code(char_code),
    .fg_colour(fg_colour), .bg_colour(bg_colour),
    .glyph_char(glyph_char), .glyph_row(glyph_row), .glyph_bits(glyph_bits),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] romRow(input logic [6:0] ch, input logic [3:0] r);
    if (ch == 7'h41) return 8'h81;
    return {1'b1, ch} ^ {r, r};
  endfunction

  // Synchronous glyph ROM plus transfer bookkeeping.
  always @(posedge clk) begin
    cycleCnt++;
    if (reset_n && char_valid && char_ready) begin
      xferCount++;
      xferCycle = cycleCnt;
    end
    glyph_bits <= romRow(glyph_char, glyph_row);
  end

  int mPx, mPy, mX, mY;
  logic [7:0] mRow;
  logic       mBit;
  logic [2:0] mCol;
  always @(negedge clk) begin
    if (plot === 1'b1) begin
      mPx = plotCount % mSpan;
      mPy = plotCount / mSpan;
      mX  = mBaseX + mPx;
      mY  = mBaseY + mPy;
      mBit = 1'b0;
      if (!mBgOnly) begin
        mRow = romRow(mChar, mPy[3:0]);
        mBit = mRow[7 - mPx];
      end
      mCol = mBit ? mFg : mBg;
      if (int'(x) != mX || int'(y) != mY) posBad++;
      if (colour !== mCol) colBad++;
      if (int'(x) < minX) minX = int'(x);
      if (int'(x) > maxX) maxX = int'(x);
      if (int'(y) < minY) minY = int'(y);
      if (int'(y) > maxY) maxY = int'(y);
      plotCount++;
      totalPlots++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearStats();
    posBad = 0;
    colBad = 0;
    totalPlots = 0;
  endtask

  task automatic setModel(input logic [6:0] ch, input logic [2:0] fg, input logic [2:0] bg,
                          input int bx, input int by, input int span, input bit bgOnly);
    mChar = ch; mFg = fg; mBg = bg;
    mBaseX = bx; mBaseY = by; mSpan = span; mBgOnly = bgOnly;
    plotCount = 0;
    minX = 1 << 30; maxX = -1; minY = 1 << 30; maxY = -1;
  endtask

  task automatic applyStimulus(input logic [6:0] code, input logic [2:0] fg, input logic [2:0] bg,
                               input int bx, input int by, input int span, input bit bgOnly);
    int n;
    n = 0;
    @(negedge clk);
    while (char_ready !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    setModel(code, fg, bg, bx, by, span, bgOnly);
    char_code  = code;
    fg_colour  = fg;
    bg_colour  = bg;
    char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic waitReady(input int budget, output int latency);
    int n;
    n = 0;
    latency = -1;
    while (n < budget) begin
      @(negedge clk);
      #1;
      n++;
      if (char_ready === 1'b1) begin
        latency = cycleCnt - xferCycle;
        break;
      end
    end
    checkOutput("ready_wait_expired", (latency < 0), 0);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    char_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int xferStart;
    int n;
    logic [6:0] c;
    char_valid = 1'b0;
    char_code  = '0;
    fg_colour  = '0;
    bg_colour  = '0;
    reset_n    = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_char_ready", char_ready, 1);
    checkOutput("rst_plot", plot, 0);
    checkOutput("rst_x", x, 0);
    checkOutput("rst_y", y, 0);
    checkOutput("rst_colour", colour, 0);
    checkOutput("rst_cursor_col", cursor_col, 0);
    checkOutput("rst_cursor_row", cursor_row, 0);
    checkOutput("rst_glyph_char", glyph_char, 0);
    checkOutput("rst_glyph_row", glyph_row, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // 'A' with ROM rows 8'h81: ink at the two edge columns only.
    clearStats();
    applyStimulus(7'h41, 3'b110, 3'b010, 0, 0, 8, 1'b0);
    waitReady(400, lat);
    checkOutput("A_latency", lat, 161);
    settle();
    checkOutput("A_plots", plotCount, 128);
    checkOutput("A_minx", minX, 0);
    checkOutput("A_maxx", maxX, 7);
    checkOutput("A_miny", minY, 0);
    checkOutput("A_maxy", maxY, 15);
    checkOutput("A_pos_bad", posBad, 0);
    checkOutput("A_colour_bad", colBad, 0);
    checkOutput("A_cursor_col", cursor_col, 1);
    checkOutput("A_cursor_row", cursor_row, 0);

    // Twenty characters fill row 0 and wrap to row 1.
    doReset();
    clearStats();
    for (int i = 0; i < 20; i++) begin
      c = 7'(8'h61 + i);
      applyStimulus(c, 3'b111, 3'b000, i * 8, 0, 8, 1'b0);
      waitReady(400, lat);
    end
    settle();
    checkOutput("row_fill_cursor_col", cursor_col, 0);
    checkOutput("row_fill_cursor_row", cursor_row, 1);
    checkOutput("row_fill_plots", totalPlots, 2560);
    checkOutput("row_fill_pos_bad", posBad, 0);
    checkOutput("row_fill_colour_bad", colBad, 0);

    applyStimulus(7'h0A, 3'b111, 3'b000, 0, 0, 8, 1'b0);
    waitReady(10, lat);
    checkOutput("nl_latency", lat, 2);
    settle();
    checkOutput("nl_cursor_row", cursor_row, 2);
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2 == 0) ? 7'h0D : 7'h0A, 3'b111, 3'b000, 0, 0, 8, 1'b0);
      waitReady(10, lat);
    end
    settle();
    checkOutput("nl_wrap_cursor_col", cursor_col, 0);
    checkOutput("nl_wrap_cursor_row", cursor_row, 1);
    checkOutput("nl_no_plots", totalPlots, 2560);

    // Backspace from the start of row 1 erases the last cell of row 0.
    clearStats();
    applyStimulus(7'h08, 3'b111, 3'b101, 152, 0, 8, 1'b1);
    waitReady(400, lat);
    checkOutput("bs_latency", lat, 161);
    settle();
    checkOutput("bs_cursor_col", cursor_col, 19);
    checkOutput("bs_cursor_row", cursor_row, 0);
    checkOutput("bs_plots", plotCount, 128);
    checkOutput("bs_minx", minX, 152);
    checkOutput("bs_maxx", maxX, 159);
    checkOutput("bs_maxy", maxY, 15);
    checkOutput("bs_pos_bad", posBad, 0);
    checkOutput("bs_colour_bad", colBad, 0);

    doReset();
    clearStats();
    applyStimulus(7'h08, 3'b111, 3'b101, 0, 0, 8, 1'b1);
    waitReady(10, lat);
    settle();
    checkOutput("bs_origin_plots", totalPlots, 0);
    checkOutput("bs_origin_col", cursor_col, 0);
    checkOutput("bs_origin_row", cursor_row, 0);

    // Full-screen clear after moving the cursor off the origin.
    applyStimulus(7'h5A, 3'b100, 3'b000, 0, 0, 8, 1'b0);
    waitReady(400, lat);
    checkOutput("pre_clear_cursor_col", cursor_col, 1);
    clearStats();
    applyStimulus(7'h0C, 3'b110, 3'b001, 0, 0, 160, 1'b1);
    waitReady(20000, lat);
    settle();
    checkOutput("clr_plots", plotCount, 17920);
    checkOutput("clr_minx", minX, 0);
    checkOutput("clr_maxx", maxX, 159);
    checkOutput("clr_miny", minY, 0);
    checkOutput("clr_maxy", maxY, 111);
    checkOutput("clr_pos_bad", posBad, 0);
    checkOutput("clr_colour_bad", colBad, 0);
    checkOutput("clr_cursor_col", cursor_col, 0);
    checkOutput("clr_cursor_row", cursor_row, 0);

    // Reset at the 40th plot of a glyph aborts the draw.
    doReset();
    clearStats();
    applyStimulus(7'h41, 3'b110, 3'b010, 0, 0, 8, 1'b0);
    n = 0;
    while (plotCount < 40 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("abort_reached_40", plotCount, 40);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_plot_low", plot, 0);
    checkOutput("abort_char_ready", char_ready, 1);
    checkOutput("abort_cursor_col", cursor_col, 0);
    checkOutput("abort_cursor_row", cursor_row, 0);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("abort_no_more_plots", plotCount, 40);
    reset_n = 1'b1;
    clearStats();
    applyStimulus(7'h42, 3'b101, 3'b001, 0, 0, 8, 1'b0);
    waitReady(400, lat);
    checkOutput("B_latency", lat, 161);
    settle();
    checkOutput("B_plots", plotCount, 128);
    checkOutput("B_minx", minX, 0);
    checkOutput("B_maxx", maxX, 7);
    checkOutput("B_pos_bad", posBad, 0);
    checkOutput("B_colour_bad", colBad, 0);

    // 0x7F is discarded; a held char_valid is only taken when ready.
    clearStats();
    applyStimulus(7'h7F, 3'b111, 3'b000, 0, 0, 8, 1'b0);
    waitReady(10, lat);
    checkOutput("del_latency", lat, 1);
    settle();
    checkOutput("del_plots", totalPlots, 0);
    checkOutput("del_cursor_col", cursor_col, 1);

    xferStart = xferCount;
    setModel(7'h43, 3'b011, 3'b100, 8, 0, 8, 1'b0);
    char_code  = 7'h43;
    fg_colour  = 3'b011;
    bg_colour  = 3'b100;
    char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    char_code = 7'h44;
    checkOutput("hold_busy", char_ready, 0);
    checkOutput("hold_first_accept", xferCount - xferStart, 1);
    waitReady(400, lat);
    checkOutput("hold_C_latency", lat, 161);
    checkOutput("hold_single_accept", xferCount - xferStart, 1);
    checkOutput("hold_C_plots", plotCount, 128);
    checkOutput("hold_C_pos_bad", posBad, 0);
    setModel(7'h44, 3'b011, 3'b100, 16, 0, 8, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    char_valid = 1'b0;
    checkOutput("hold_second_accept", xferCount - xferStart, 2);
    checkOutput("hold_D_glyph_char", glyph_char, 7'h44);
    waitReady(400, lat);
    settle();
    checkOutput("hold_D_plots", plotCount, 128);
    checkOutput("hold_pos_bad", posBad, 0);
    checkOutput("hold_colour_bad", colBad, 0);
    checkOutput("hold_cursor_col", cursor_col, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
